// File: rtl/uop_group_retire_if.sv
// Micro-op completion and retire-event bundle between writeback and uop_group_retire.
interface uop_group_retire_if #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = 6
);
    logic                 uop_valid;
    logic                 uop_ready;
    logic                 uop_first;
    logic                 uop_last;
    logic [PC_WIDTH-1:0]  uop_pc;
    logic                 uop_exc;
    logic                 flush;
    logic                 retire_valid;
    logic                 retire_ready;
    logic [PC_WIDTH-1:0]  retire_pc;
    logic [CNT_WIDTH-1:0] retire_nuop;
    logic                 retire_exc;
    logic                 group_err;
    logic                 busy;

    modport master (
        output uop_valid, uop_first, uop_last, uop_pc, uop_exc, flush, retire_ready,
        input  uop_ready, retire_valid, retire_pc, retire_nuop, retire_exc, group_err, busy
    );

    modport slave (
        input  uop_valid, uop_first, uop_last, uop_pc, uop_exc, flush, retire_ready,
        output uop_ready, retire_valid, retire_pc, retire_nuop, retire_exc, group_err, busy
    );
endinterface

// File: rtl/uop_group_retire.sv
// Merges first/last-tagged completing micro-ops into one architectural retire event per instruction.
// Optional UOP_RETIRE_EARLY_EXC_EN: an excepting micro-op closes its group and the tail is drained.
module uop_group_retire #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    uop_group_retire_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(32);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
`ifdef UOP_RETIRE_EARLY_EXC_EN
        , DRAIN = 2'd3
`endif
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [PC_WIDTH-1:0]  pc_q;
    logic                 exc_q;
    logic                 ret_valid;
    logic [PC_WIDTH-1:0]  ret_pc;
    logic [CNT_WIDTH-1:0] ret_nuop;
    logic                 ret_exc;
    logic                 err_pulse;
    logic                 busy_r;

    logic                 accept;
    logic                 start;
    logic                 pc_match;
    logic                 sat_hit;
    logic                 exc_close;
    logic                 drop_quiet;
    logic [CNT_WIDTH-1:0] cnt_inc;

    assign bus.uop_ready    = (state != HOLD) | bus.retire_ready;
    assign bus.retire_valid = ret_valid;
    assign bus.retire_pc    = ret_pc;
    assign bus.retire_nuop  = ret_nuop;
    assign bus.retire_exc   = ret_exc;
    assign bus.group_err    = err_pulse;
    assign bus.busy         = busy_r;

    // A micro-op in the flush cycle is never taken, even with uop_ready high.
    assign accept   = bus.uop_valid & bus.uop_ready & ~bus.flush;
    assign start    = accept & bus.uop_first;
    assign pc_match = (bus.uop_pc == pc_q);
    assign sat_hit  = (cnt == CNT_MAX);
    assign cnt_inc  = cnt + CNT_ONE;

`ifdef UOP_RETIRE_EARLY_EXC_EN
    logic drain_pend;
    logic early_close;

    assign exc_close   = bus.uop_exc;
    assign drop_quiet  = (state == DRAIN) | drain_pend;
    assign early_close = accept & bus.uop_exc & ~bus.uop_last &
                         (bus.uop_first | ((state == ACCUM) & pc_match & ~sat_hit));

    // Remembers that the group in HOLD was cut short, so its tail must be drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_pend <= 1'b0;
        end else if (bus.flush) begin
            drain_pend <= 1'b0;
        end else if (early_close) begin
            drain_pend <= 1'b1;
        end else if ((state == HOLD) && bus.retire_ready) begin
            drain_pend <= 1'b0;
        end
    end
`else
    assign exc_close  = 1'b0;
    assign drop_quiet = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pc_q      <= '0;
            exc_q     <= 1'b0;
            ret_valid <= 1'b0;
            ret_pc    <= '0;
            ret_nuop  <= '0;
            ret_exc   <= 1'b0;
            err_pulse <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (bus.flush) begin
                state     <= IDLE;
                cnt       <= '0;
                ret_valid <= 1'b0;
                busy_r    <= 1'b0;
            end else if (start) begin
                // A first micro-op always opens a new group; an open one is abandoned.
                err_pulse <= (state == ACCUM);
                if (bus.uop_last || exc_close) begin
                    state     <= HOLD;
                    ret_valid <= 1'b1;
                    busy_r    <= 1'b0;
                    cnt       <= '0;
                    ret_pc    <= bus.uop_pc;
                    ret_nuop  <= CNT_ONE;
                    ret_exc   <= bus.uop_exc;
                end else begin
                    state     <= ACCUM;
                    ret_valid <= 1'b0;
                    busy_r    <= 1'b1;
                    cnt       <= CNT_ONE;
                    pc_q      <= bus.uop_pc;
                    exc_q     <= bus.uop_exc;
                end
            end else if (state == ACCUM) begin
                if (accept) begin
                    if (!pc_match) begin
                        err_pulse <= 1'b1;
                    end else if (sat_hit && !bus.uop_last) begin
                        // Group overran the counter: close it as excepting.
                        err_pulse <= 1'b1;
                        state     <= HOLD;
                        ret_valid <= 1'b1;
                        busy_r    <= 1'b0;
                        cnt       <= '0;
                        ret_pc    <= pc_q;
                        ret_nuop  <= CNT_MAX;
                        ret_exc   <= 1'b1;
                    end else if (bus.uop_last || exc_close) begin
                        state     <= HOLD;
                        ret_valid <= 1'b1;
                        busy_r    <= 1'b0;
                        cnt       <= '0;
                        ret_pc    <= pc_q;
                        ret_nuop  <= cnt_inc;
                        ret_exc   <= exc_q | bus.uop_exc;
                    end else begin
                        cnt   <= cnt_inc;
                        exc_q <= exc_q | bus.uop_exc;
                    end
                end
            end else if (state == HOLD) begin
                if (bus.retire_ready) begin
                    ret_valid <= 1'b0;
                    err_pulse <= accept & ~drop_quiet;
`ifdef UOP_RETIRE_EARLY_EXC_EN
                    state     <= drop_quiet ? DRAIN : IDLE;
`else
                    state     <= IDLE;
`endif
                end
            end else begin
                // IDLE flags orphan micro-ops; DRAIN swallows them silently.
                err_pulse <= accept & ~drop_quiet;
            end
        end
    end
endmodule

// File: tb/tb_uop_group_retire.sv
// Self-checking bench for uop_group_retire: directed scenarios plus a randomized run against a group-level model.
`timescale 1ns/1ps
module tb_uop_group_retire;
    localparam int unsigned PC_WIDTH  = 32;
    localparam int unsigned CNT_WIDTH = 6;
`ifdef UOP_RETIRE_EARLY_EXC_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uop_group_retire_if #(.PC_WIDTH(PC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();
    uop_group_retire #(.PC_WIDTH(PC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int dut_retires = 0;

    always @(posedge clk)
        if (rst_n && bus.retire_valid && bus.retire_ready) dut_retires <= dut_retires + 1;

    // Model: one pending retire event plus one open group, tracked at instruction level.
    bit          m_rv, m_exc, m_err, m_open, m_gexc, m_skip;
    logic [31:0] m_pc, m_gpc;
    int          m_nuop, m_gcnt;
    int          m_retires = 0;

    task automatic model_reset();
        m_rv = 0; m_exc = 0; m_err = 0; m_open = 0; m_gexc = 0; m_skip = 0;
        m_pc = '0; m_gpc = '0; m_nuop = 0; m_gcnt = 0;
    endtask

    task automatic model_retire(input logic [31:0] pc, input int n, input bit exc);
        m_rv = 1; m_pc = pc; m_nuop = n; m_exc = exc; m_open = 0;
    endtask

    task automatic model_step();
        bit rdy, acc;
        bit n_err;
        rdy   = !m_rv || bus.retire_ready;
        acc   = bus.uop_valid && rdy && !bus.flush;
        n_err = 0;
        if (m_rv && bus.retire_ready) begin m_retires++; m_rv = 0; end
        if (bus.flush) begin
            m_open = 0; m_skip = 0; m_rv = 0;
        end else if (acc) begin
            if (bus.uop_first) begin
                n_err  = m_open;
                m_open = 0; m_skip = 0;
                if (bus.uop_last || (EARLY && bus.uop_exc)) begin
                    model_retire(bus.uop_pc, 1, bus.uop_exc);
                    m_skip = !bus.uop_last;
                end else begin
                    m_open = 1; m_gpc = bus.uop_pc; m_gcnt = 1; m_gexc = bus.uop_exc;
                end
            end else if (m_open) begin
                if (bus.uop_pc != m_gpc) n_err = 1;
                else if (m_gcnt == 32 && !bus.uop_last) begin
                    n_err = 1;
                    model_retire(m_gpc, 32, 1'b1);
                end else begin
                    m_gcnt++;
                    m_gexc = m_gexc | bus.uop_exc;
                    if (bus.uop_last || (EARLY && bus.uop_exc)) begin
                        model_retire(m_gpc, m_gcnt, m_gexc);
                        m_skip = !bus.uop_last;
                    end
                end
            end else if (!m_skip) begin
                n_err = 1;
            end
        end
        m_err = n_err;
    endtask

    task automatic drive(input bit v, input bit f, input bit l, input logic [31:0] pc,
                         input bit e, input bit fl, input bit rr);
        bus.uop_valid = v; bus.uop_first = f; bus.uop_last = l; bus.uop_pc = pc;
        bus.uop_exc = e; bus.flush = fl; bus.retire_ready = rr;
        #1;
    endtask

    task automatic idle(input bit rr);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, rr);
    endtask

    task automatic tick();
        if (rst_n) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b want 0", bus.retire_valid); end
        checks++; if (bus.retire_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus.retire_pc); end
        checks++; if (bus.retire_nuop !== 6'd0) begin errors++; $display("FAIL reset_nuop: got %0d want 0", bus.retire_nuop); end
        checks++; if (bus.retire_exc !== 1'b0) begin errors++; $display("FAIL reset_exc: got %b want 0", bus.retire_exc); end
        checks++; if (bus.group_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.group_err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.uop_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.uop_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (bus.retire_valid !== 1'b1) begin errors++; $display("FAIL single_rv: got %b want 1", bus.retire_valid); end
        checks++; if (bus.retire_pc !== 32'h100) begin errors++; $display("FAIL single_pc: got %h want 100", bus.retire_pc); end
        checks++; if (bus.retire_nuop !== 6'd1) begin errors++; $display("FAIL single_nuop: got %0d want 1", bus.retire_nuop); end
        checks++; if (bus.retire_exc !== 1'b0) begin errors++; $display("FAIL single_exc: got %b want 0", bus.retire_exc); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", bus.busy); end
        idle(1'b1);
        tick();
        checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL single_rv_drop: got %b want 0", bus.retire_valid); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = dut_retires;
        drive(1'b1, 1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", bus.busy); end
        drive(1'b1, 1'b0, 1'b1, 32'h104, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (bus.retire_valid !== 1'b1 || bus.retire_pc !== 32'h104 || bus.retire_nuop !== 6'd2)
            begin errors++; $display("FAIL b2b_lwzu: got rv=%b pc=%h n=%0d want rv=1 pc=104 n=2", bus.retire_valid, bus.retire_pc, bus.retire_nuop); end
        drive(1'b1, 1'b1, 1'b1, 32'h108, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.uop_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", bus.uop_ready); end
        tick();
        checks++; if (bus.retire_valid !== 1'b1 || bus.retire_pc !== 32'h108 || bus.retire_nuop !== 6'd1)
            begin errors++; $display("FAIL b2b_second: got rv=%b pc=%h n=%0d want rv=1 pc=108 n=1", bus.retire_valid, bus.retire_pc, bus.retire_nuop); end
        idle(1'b1);
        tick();
        checks++; if (dut_retires - base !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", dut_retires - base); end
    endtask

    task automatic test_hold();
        drive(1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
            checks++; if (bus.uop_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 0", i, bus.uop_ready); end
            tick();
            checks++; if (bus.retire_valid !== 1'b1 || bus.retire_pc !== 32'h200 || bus.retire_nuop !== 6'd5)
                begin errors++; $display("FAIL hold_stable[%0d]: got rv=%b pc=%h n=%0d want rv=1 pc=200 n=5", i, bus.retire_valid, bus.retire_pc, bus.retire_nuop); end
        end
        drive(1'b1, 1'b1, 1'b1, 32'h204, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.uop_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got %b want 1", bus.uop_ready); end
        tick();
        checks++; if (bus.retire_valid !== 1'b1 || bus.retire_pc !== 32'h204 || bus.retire_nuop !== 6'd1)
            begin errors++; $display("FAIL hold_next: got rv=%b pc=%h n=%0d want rv=1 pc=204 n=1", bus.retire_valid, bus.retire_pc, bus.retire_nuop); end
        idle(1'b1);
        tick();
    endtask

    task automatic test_exception();
        int base, seen_step, err_sum;
        logic [31:0] seen_pc;
        logic [5:0]  seen_n;
        logic        seen_exc;
        bit          exc_pat [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        base = dut_retires; seen_step = 0; err_sum = 0;
        seen_pc = '0; seen_n = '0; seen_exc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, i == 3, 32'h300, exc_pat[i], 1'b0, 1'b1);
            tick();
            err_sum += int'(bus.group_err);
            if (bus.retire_valid && seen_step == 0) begin
                seen_step = i + 1; seen_pc = bus.retire_pc; seen_n = bus.retire_nuop; seen_exc = bus.retire_exc;
            end
        end
        idle(1'b1);
        tick();
        checks++; if (seen_step !== (EARLY ? 2 : 4)) begin errors++; $display("FAIL exc_step: got %0d want %0d", seen_step, EARLY ? 2 : 4); end
        checks++; if (seen_n !== (EARLY ? 6'd2 : 6'd4)) begin errors++; $display("FAIL exc_nuop: got %0d want %0d", seen_n, EARLY ? 2 : 4); end
        checks++; if (seen_exc !== 1'b1 || seen_pc !== 32'h300) begin errors++; $display("FAIL exc_flag: got exc=%b pc=%h want exc=1 pc=300", seen_exc, seen_pc); end
        checks++; if (err_sum !== 0) begin errors++; $display("FAIL exc_err: got %0d pulses want 0", err_sum); end
        checks++; if (dut_retires - base !== 1) begin errors++; $display("FAIL exc_count: got %0d want 1", dut_retires - base); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_flush();
        int base;
        base = dut_retires;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i == 0, 1'b0, 32'h380, 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h380, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.retire_valid !== 1'b0 || bus.group_err !== 1'b0)
            begin errors++; $display("FAIL flush_state: got busy=%b rv=%b err=%b want 0 0 0", bus.busy, bus.retire_valid, bus.group_err); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, i == 2, 32'h380, 1'b0, 1'b0, 1'b1);
            tick();
            checks++; if (bus.group_err !== 1'b1 || bus.retire_valid !== 1'b0)
                begin errors++; $display("FAIL flush_orphan[%0d]: got err=%b rv=%b want err=1 rv=0", i, bus.group_err, bus.retire_valid); end
        end
        drive(1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (bus.retire_valid !== 1'b1 || bus.retire_pc !== 32'h400 || bus.retire_nuop !== 6'd1)
            begin errors++; $display("FAIL flush_next: got rv=%b pc=%h n=%0d want rv=1 pc=400 n=1", bus.retire_valid, bus.retire_pc, bus.retire_nuop); end
        idle(1'b1);
        tick();
        checks++; if (dut_retires - base !== 1) begin errors++; $display("FAIL flush_count: got %0d want 1", dut_retires - base); end
    endtask

    task automatic test_protocol();
        drive(1'b1, 1'b0, 1'b0, 32'h440, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (bus.group_err !== 1'b1 || bus.retire_valid !== 1'b0)
            begin errors++; $display("FAIL proto_orphan: got err=%b rv=%b want err=1 rv=0", bus.group_err, bus.retire_valid); end
        idle(1'b1);
        tick();
        checks++; if (bus.group_err !== 1'b0) begin errors++; $display("FAIL proto_pulse: got %b want 0", bus.group_err); end
        drive(1'b1, 1'b1, 1'b0, 32'h500, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h504, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (bus.group_err !== 1'b1 || bus.busy !== 1'b1)
            begin errors++; $display("FAIL proto_pcmis: got err=%b busy=%b want 1 1", bus.group_err, bus.busy); end
        drive(1'b1, 1'b0, 1'b0, 32'h500, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (bus.retire_valid !== 1'b1 || bus.retire_nuop !== 6'd3 || bus.retire_pc !== 32'h500 || bus.group_err !== 1'b0)
            begin errors++; $display("FAIL proto_close: got rv=%b n=%0d pc=%h err=%b want rv=1 n=3 pc=500 err=0", bus.retire_valid, bus.retire_nuop, bus.retire_pc, bus.group_err); end
        idle(1'b1);
        tick();
    endtask

    task automatic test_saturate();
        drive(1'b1, 1'b1, 1'b0, 32'h700, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h700, 1'b0, 1'b0, 1'b1);
            tick();
        end
        checks++; if (bus.busy !== 1'b1 || bus.retire_valid !== 1'b0) begin errors++; $display("FAIL sat_open: got busy=%b rv=%b want 1 0", bus.busy, bus.retire_valid); end
        drive(1'b1, 1'b0, 1'b0, 32'h700, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (bus.retire_valid !== 1'b1 || bus.retire_nuop !== 6'd32 || bus.retire_exc !== 1'b1 || bus.group_err !== 1'b1)
            begin errors++; $display("FAIL sat_close: got rv=%b n=%0d exc=%b err=%b want 1 32 1 1", bus.retire_valid, bus.retire_nuop, bus.retire_exc, bus.group_err); end
        idle(1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h710, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h710, 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, 32'h710, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (bus.retire_valid !== 1'b1 || bus.retire_nuop !== 6'd32 || bus.retire_exc !== 1'b0 || bus.group_err !== 1'b0)
            begin errors++; $display("FAIL lmw32: got rv=%b n=%0d exc=%b err=%b want 1 32 0 0", bus.retire_valid, bus.retire_nuop, bus.retire_exc, bus.group_err); end
        idle(1'b1);
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b0, 32'h720, 1'b0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        model_reset();
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h730, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.retire_valid !== 1'b0 || bus.retire_pc !== 32'h0) begin errors++; $display("FAIL rstmid_hold: got rv=%b pc=%h want 0 0", bus.retire_valid, bus.retire_pc); end
        model_reset();
        rst_n = 1'b1;
        idle(1'b1);
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                  ($urandom_range(0, 7) == 0) ? 32'h604 : 32'h600, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 7);
            checks++; if (bus.uop_ready !== (!m_rv || bus.retire_ready)) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, bus.uop_ready, !m_rv || bus.retire_ready); end
            tick();
            checks++; if (bus.retire_valid !== m_rv || bus.group_err !== m_err || bus.busy !== m_open)
                begin errors++; $display("FAIL rnd_ctrl[%0d]: got rv=%b err=%b busy=%b want %b %b %b", c, bus.retire_valid, bus.group_err, bus.busy, m_rv, m_err, m_open); end
            if (m_rv) begin
                checks++; if (bus.retire_pc !== m_pc || bus.retire_nuop !== CNT_WIDTH'(m_nuop) || bus.retire_exc !== m_exc)
                    begin errors++; $display("FAIL rnd_event[%0d]: got pc=%h n=%0d exc=%b want %h %0d %b", c, bus.retire_pc, bus.retire_nuop, bus.retire_exc, m_pc, m_nuop, m_exc); end
            end
        end
        idle(1'b1);
        tick();
        checks++; if (dut_retires !== m_retires) begin errors++; $display("FAIL rnd_count: got %0d want %0d", dut_retires, m_retires); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_exception();
        test_flush();
        test_protocol();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uop_group_retire.md
Name: uop_group_retire

Overview:
- Retire-side counterpart of the fetch-side instruction cracker. The cracker splits update-form loads/stores into 2 micro-ops, and lmw/stmw into 1..32 micro-ops.
- This block sits after writeback. It collects completing micro-ops tagged first/last and emits exactly one architectural retire event per original instruction.
- The retire event carries the original PC, the micro-op count and a merged exception flag.

Parameters:
- PC_WIDTH, 32, width of original-instruction PC.
- CNT_WIDTH, 6, micro-op counter width; must hold 32 (lmw r0).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- uop_valid  in  1  completing micro-op present
- uop_ready  out  1  block accepts micro-op this cycle
- uop_first  in  1  first micro-op of its instruction
- uop_last  in  1  last micro-op of its instruction
- uop_pc  in  PC_WIDTH  PC of the original instruction
- uop_exc  in  1  micro-op raised exception
- flush  in  1  pipeline flush, synchronous
- retire_valid  out  1  retire event pending
- retire_ready  in  1  consumer takes retire event
- retire_pc  out  PC_WIDTH  PC of retired instruction
- retire_nuop  out  CNT_WIDTH  micro-ops merged into this instruction
- retire_exc  out  1  OR of uop_exc over the group
- group_err  out  1  one-cycle pulse on protocol violation
- busy  out  1  group partially collected (state ACCUM)

Behaviour:
- Reset values: state IDLE; retire_valid 0, retire_pc 0, retire_nuop 0, retire_exc 0, group_err 0, busy 0. uop_ready is 1 immediately after reset.
- An accept occurs when uop_valid & uop_ready. All outputs except uop_ready are registered.
- uop_ready = (state != HOLD) | retire_ready.
- Latency: retire_valid rises the cycle after the accept of the last micro-op.
- Retire handshake:
  - retire_pc, retire_nuop and retire_exc stay stable while retire_valid=1 and retire_ready=0.
  - The event completes on retire_valid & retire_ready.
- IDLE:
  - Accept with first=1, last=1: go to HOLD; nuop=1, pc=uop_pc, exc=uop_exc.
  - Accept with first=1, last=0: go to ACCUM; cnt=1, latch pc and exc.
  - Accept with first=0: drop the micro-op, pulse group_err, stay in IDLE.
- ACCUM:
  - Accept with first=0 and uop_pc==latched pc: cnt+1, exc |= uop_exc. If last=1, go to HOLD with nuop=cnt+1.
  - Accept with first=1: pulse group_err, discard the partial group, restart the group with this micro-op (IDLE rules).
  - Accept with uop_pc != latched pc: pulse group_err, drop the micro-op, stay in ACCUM.
  - Counter saturation: if cnt==32 and last=0 is accepted, pulse group_err and force the group closed to HOLD with nuop=32, exc=1.
- HOLD:
  - retire_valid=1.
  - On retire_ready, a micro-op accepted in the same cycle is processed by IDLE rules. This gives back-to-back retires with no bubble.
  - Without a new micro-op, go to IDLE.
- Flush has highest priority:
  - Next state IDLE, cnt 0, retire_valid 0, group_err 0.
  - A micro-op presented in the flush cycle is discarded, even when uop_ready=1.
- Reset mid-group or mid-HOLD: immediate return to reset values; the pending retire is lost.
- Width rule: nuop/cnt arithmetic is unsigned CNT_WIDTH; no wrap is permitted (saturation rule above).

Optional Feature:
- Macro: UOP_RETIRE_EARLY_EXC_EN.
- Defined:
  - An accepted micro-op with uop_exc=1 closes the group immediately: go to HOLD with nuop=cnt incl. this micro-op, exc=1.
  - The remaining micro-ops of that group (first=0) are silently dropped via a DRAIN state until the next first=1 micro-op.
  - DRAIN asserts uop_ready=1 and raises no group_err.
  - A flush exits DRAIN.
- Undefined: exceptions only accumulate into exc; the group closes on uop_last. DRAIN does not exist.

Test Plan:
- Single micro-op first=last=1, pc=0x100, retire_ready=1 → next cycle retire_valid=1, retire_pc=0x100, retire_nuop=1, retire_exc=0; busy never set.
- lwzu cracked into 2 micro-ops pc=0x104 on consecutive cycles → one retire, nuop=2. A following single micro-op pc=0x108 in the retire cycle → back-to-back retire, no bubble.
- lmw r27 (5 micro-ops pc=0x200), retire_ready held 0 for 3 cycles after the close:
  - uop_ready=0 during hold; retire_pc=0x200 and nuop=5 stay stable.
  - Released on retire_ready=1.
- Exception on micro-op 2 of 4, pc=0x300:
  - Macro undefined → retire after micro-op 4 with nuop=4, exc=1.
  - Macro defined → retire after micro-op 2 with nuop=2, exc=1; micro-ops 3 and 4 dropped, group_err stays 0.
- flush after 3 of 6 lmw micro-ops, remaining 3 then sent, then single pc=0x400:
  - State IDLE after flush, busy=0.
  - Each of the 3 orphan micro-ops pulses group_err.
  - Exactly one retire results: pc=0x400, nuop=1.
- Protocol errors:
  - first=0 in IDLE → group_err 1-cycle pulse, no retire.
  - pc mismatch 0x500/0x504 mid-group → group_err pulse, mismatched micro-op dropped, group still closes with the correct nuop.
